// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential divider: default operand width, the
// step-counter landmarks (load step and done step), the counter width, and the
// phase encoding decoded from the step counter.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  // Default operand/result width.
  localparam int DIV_W_DEFAULT = 32;

  // Step counter landmarks for the default width.
  localparam int S_LOAD = 0;
  localparam int S_DONE = DIV_W_DEFAULT + 1;

  // Counter must hold 0..W+1.
  localparam int CNT_W = $clog2(DIV_W_DEFAULT + 2);

  // Width-generic versions of the landmarks, for non-default W.
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

  function automatic int done_step(input int w);
    return w + 1;
  endfunction

  // Operating phase, decoded from run and the step counter.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,  // run low: counter parked at S_LOAD
    PH_LOAD = 2'd1,  // S == S_LOAD: sample operands
    PH_ITER = 2'd2,  // S == 1..W: one quotient bit per cycle
    PH_DONE = 2'd3   // S == W+1: result valid, counter saturated
  } div_phase_e;

endpackage

// File: rtl/seq_divider_div_sign_fixup.sv
// -----------------------------------------------------------------------------
// seq_divider_div_sign_fixup
// Purely combinational sign/floor correction applied to the magnitude result
// of the shift-subtract core.
//   qreg, rem_reg : unsigned magnitude quotient / remainder
//   y             : divisor as sampled (two's complement when signed)
//   x_saved       : dividend as sampled (returned as remainder on divide by 0)
//   neg_x, neg_y  : operand signs (already qualified by signed mode)
//   u             : 1 = signed floored divide, 0 = unsigned
//   div0          : divisor was zero
//   quot, rem     : final quotient / remainder
// -----------------------------------------------------------------------------
module seq_divider_div_sign_fixup
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic [W-1:0] qreg,
  input  logic [W-1:0] rem_reg,
  input  logic [W-1:0] y,
  input  logic [W-1:0] x_saved,
  input  logic         neg_x,
  input  logic         neg_y,
  input  logic         u,
  input  logic         div0,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic [W-1:0] qt;
  logic [W-1:0] rt;

  // Truncated signed result, then floor adjustment or divide-by-zero override.
  always_comb begin
    qt   = ZERO;
    rt   = ZERO;
    quot = ZERO;
    rem  = ZERO;

    // Quotient is negative when exactly one operand is; remainder follows x.
    if (neg_x ^ neg_y) begin
      qt = ZERO - qreg;
    end else begin
      qt = qreg;
    end

    if (neg_x) begin
      rt = ZERO - rem_reg;
    end else begin
      rt = rem_reg;
    end

    if (div0) begin
      quot = ONES;
      rem  = x_saved;
    end else if (u && (neg_x ^ neg_y) && (rt != ZERO)) begin
      // Truncation rounded toward zero; step down one so rem takes y's sign.
      quot = qt - ONE;
      rem  = rt + y;
    end else begin
      quot = qt;
      rem  = rt;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle integer divider using the same run/stall handshake as the
// sequential multiplier. Restoring shift-subtract on magnitudes, one quotient
// bit per clock, with a combinational sign/floor fixup on the registered result.
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active low
//   run   : divide request, held high until stall drops
//   u     : 1 = signed (floored) divide, 0 = unsigned
//   x, y  : dividend / divisor, sampled only in the load step
//   stall : high while a requested divide is in progress
//   quot  : quotient (valid when run = 1 and stall = 0)
//   rem   : remainder (valid when run = 1 and stall = 0)
// With run held from the first cycle, stall stays high for W+1 cycles.
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         u,
  output logic         stall,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] S_LOAD_C = CW'(S_LOAD);
  localparam logic [CW-1:0] S_DONE_C = CW'(done_step(W));
  localparam logic [CW-1:0] S_ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ZERO     = {W{1'b0}};

  logic [CW-1:0] s_q,     s_d;
  logic [W-1:0]  rem_q,   rem_d;    // partial remainder
  logic [W-1:0]  qreg_q,  qreg_d;   // |x| shifting out, quotient shifting in
  logic [W-1:0]  ymag_q,  ymag_d;   // |y|
  logic [W-1:0]  y_q,     y_d;      // y as sampled, for the floor correction
  logic [W-1:0]  x_q,     x_d;      // x as sampled, for the divide-by-zero result
  logic          neg_x_q, neg_x_d;
  logic          neg_y_q, neg_y_d;
  logic          div0_q,  div0_d;
  logic          u_q,     u_d;

  div_phase_e    phase;
  logic [W:0]    trial;             // {rem, next dividend bit} - |y|

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q     <= S_LOAD_C;
      rem_q   <= ZERO;
      qreg_q  <= ZERO;
      ymag_q  <= ZERO;
      y_q     <= ZERO;
      x_q     <= ZERO;
      neg_x_q <= 1'b0;
      neg_y_q <= 1'b0;
      div0_q  <= 1'b0;
      u_q     <= 1'b0;
    end else begin
      s_q     <= s_d;
      rem_q   <= rem_d;
      qreg_q  <= qreg_d;
      ymag_q  <= ymag_d;
      y_q     <= y_d;
      x_q     <= x_d;
      neg_x_q <= neg_x_d;
      neg_y_q <= neg_y_d;
      div0_q  <= div0_d;
      u_q     <= u_d;
    end
  end

  // Phase decode from run and the step counter.
  always_comb begin
    phase = PH_IDLE;
    if (!run) begin
      phase = PH_IDLE;
    end else if (s_q == S_LOAD_C) begin
      phase = PH_LOAD;
    end else if (s_q == S_DONE_C) begin
      phase = PH_DONE;
    end else if (s_q < S_DONE_C) begin
      phase = PH_ITER;
    end else begin
      // Unreachable counter value: park and restart.
      phase = PH_IDLE;
    end
  end

  // Next-state: counter sequencing, operand load and shift-subtract step.
  always_comb begin
    s_d     = s_q;
    rem_d   = rem_q;
    qreg_d  = qreg_q;
    ymag_d  = ymag_q;
    y_d     = y_q;
    x_d     = x_q;
    neg_x_d = neg_x_q;
    neg_y_d = neg_y_q;
    div0_d  = div0_q;
    u_d     = u_q;
    // Top bit is set exactly when the trial subtraction went negative, because
    // the partial remainder is always below |y|.
    trial   = {rem_q, qreg_q[W-1]} - {1'b0, ymag_q};

    case (phase)
      PH_IDLE: begin
        s_d = S_LOAD_C;
      end
      PH_LOAD: begin
        s_d     = s_q + S_ONE_C;
        u_d     = u;
        neg_x_d = u & x[W-1];
        neg_y_d = u & y[W-1];
        div0_d  = (y == ZERO);
        x_d     = x;
        y_d     = y;
        rem_d   = ZERO;
        // Two's-complement negation: the most negative value maps to 2^(W-1).
        qreg_d  = (u & x[W-1]) ? (ZERO - x) : x;
        ymag_d  = (u & y[W-1]) ? (ZERO - y) : y;
      end
      PH_ITER: begin
        s_d = s_q + S_ONE_C;
        if (!trial[W]) begin
          rem_d  = trial[W-1:0];
          qreg_d = {qreg_q[W-2:0], 1'b1};
        end else begin
          rem_d  = {rem_q[W-2:0], qreg_q[W-1]};
          qreg_d = {qreg_q[W-2:0], 1'b0};
        end
      end
      PH_DONE: begin
        s_d = S_DONE_C;
      end
      default: begin
        s_d = S_LOAD_C;
      end
    endcase
  end

  // Handshake output: stall until the counter reaches the done step.
  always_comb begin
    stall = run & (s_q != S_DONE_C);
  end

  seq_divider_div_sign_fixup #(
    .W(W)
  ) u_fixup (
    .qreg    (qreg_q),
    .rem_reg (rem_q),
    .y       (y_q),
    .x_saved (x_q),
    .neg_x   (neg_x_q),
    .neg_y   (neg_y_q),
    .u       (u_q),
    .div0    (div0_q),
    .quot    (quot),
    .rem     (rem)
  );

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Table-driven bench for seq_divider: each vector is run as a full divide with
// run held, the stall length is counted and quot/rem compared against
// hand-computed values. Abort, reset and hold-after-done cases follow.
// Inputs change just after the falling edge; outputs are read 1 ns later.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 32;
  localparam int LAT = 33;

  logic         clk;
  logic         rst;
  logic         run;
  logic         u;
  logic         stall;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] quot;
  logic [W-1:0] rem;

  int checks;
  int errors;

  typedef struct {
    string        name;
    logic         u;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[11];

  seq_divider #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .u     (u),
    .stall (stall),
    .x     (x),
    .y     (y),
    .quot  (quot),
    .rem   (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full divide: raise run, count stall cycles, check result, optionally hold
  // run after done, then drop run for one cycle.
  task automatic run_div(input string name, input logic uu, input logic [W-1:0] xx,
                         input logic [W-1:0] yy, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input bit scramble, input int extra);
    int cnt;
    cnt = 0;
    u   = uu;
    x   = xx;
    y   = yy;
    run = 1'b1;
    #1;
    while (stall === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
      if (scramble) begin
        x = $urandom;
        y = $urandom;
      end
      #1;
    end
    chk({name, " stall_cycles"}, W'(cnt), W'(LAT));
    chk({name, " quot"}, quot, eq);
    chk({name, " rem"}, rem, er);
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      #1;
      chk({name, " hold_stall"}, {31'd0, stall}, 32'd0);
      chk({name, " hold_quot"}, quot, eq);
      chk({name, " hold_rem"}, rem, er);
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    run = 1'b0;
    u   = 1'b0;
    x   = 32'd0;
    y   = 32'd0;

    vecs[0]  = '{"unsigned_100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{"s_neg_x",         1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFC,  32'd1};
    vecs[2]  = '{"s_neg_y",         1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFC,  32'hFFFF_FFFF};
    vecs[3]  = '{"s_neg_both",      1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    vecs[4]  = '{"s_div0",          1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[5]  = '{"s_overflow",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[6]  = '{"u_max_by_1",      1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[7]  = '{"u_big_divisor",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[8]  = '{"u_div0_zero",     1'b0, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0};
    vecs[9]  = '{"s_exact_neg",     1'b1, 32'hFFFF_FFF8,  32'd4,          32'hFFFF_FFFE,  32'd0};
    vecs[10] = '{"u_neg_pattern",   1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1};

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_stall_idle", {31'd0, stall}, 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    run = 1'b1;
    #1;
    chk("rst_stall_follows_run", {31'd0, stall}, 32'd1);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_div(vecs[i].name, vecs[i].u, vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r, 1'b0, 0);
    end

    // Operands scrambled after the load step must not affect the result.
    run_div("operand_hold", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1, 0);

    // Run held after done: stall stays low and outputs stay put.
    run_div("hold_after_done", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFC, 32'd1, 1'b0, 4);

    // Abort by dropping run at S=10, then a fresh full-latency divide.
    u   = 1'b0;
    x   = 32'd100;
    y   = 32'd7;
    run = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_stall_mid", {31'd0, stall}, 32'd1);
    run = 1'b0;
    #1;
    chk("abort_stall_dropped", {31'd0, stall}, 32'd0);
    @(negedge clk);
    run_div("after_abort_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

    // Asynchronous reset at S=20 clears the result immediately.
    u   = 1'b0;
    x   = 32'd100;
    y   = 32'd7;
    run = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_stall_follows_run", {31'd0, stall}, 32'd1);
    chk("midrst_quot", quot, 32'd0);
    chk("midrst_rem", rem, 32'd0);
    run = 1'b0;
    #1;
    chk("midrst_stall_low", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_div("after_rst_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle integer divider for the RISC5 execute stage. It is the inverse operation of the sequential multiplier and uses the same run/stall handshake, so the CPU treats DIV exactly as it treats MUL.
- Computes floored quotient and remainder for signed operands, or plain quotient and remainder for unsigned operands.
- Algorithm: restoring shift-subtract on magnitudes, one quotient bit per clock, followed by a combinational sign/floor fixup on the registered result.

Parameters:
- W, 32, operand and result width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  divide request; held high by the CPU until stall drops.
- u  in  1  1 = signed (floored) divide, 0 = unsigned.
- stall  out  1  high while a requested divide is still in progress.
- x  in  W  dividend.
- y  in  W  divisor.
- quot  out  W  quotient.
- rem  out  W  remainder.

Behaviour:
- Reset (rst low, asynchronous): step counter S=0; quotient, remainder, stored-divisor and flag registers all cleared.
  - quot=0, rem=0.
  - stall = run (combinational), so it is 0 when run is low.
- Counter: S <= run ? (S==W+1 ? W+1 : S+1) : 0.
  - S saturates at W+1 while run stays high; it never wraps.
- stall = run & (S != W+1). quot and rem are valid in the cycle where run=1 and stall=0.
- Latency: with run held from cycle 0, stall is high for exactly W+1 cycles (S=0..W). The result is presented at S=W+1.
- S==0 (load):
  - Sample x, y and u. This is the only cycle they are sampled; the CPU may change them afterwards.
  - Store neg_x = u & x[W-1], neg_y = u & y[W-1], div0 = (y==0) and y itself.
  - Load the partial remainder with 0 and the quotient shift register with |x|. |y| is held in a register.
  - Magnitudes use two's-complement negation in W bits, so |-2^(W-1)| = 2^(W-1) as unsigned.
- S=1..W (iterate, one step per cycle):
  - Form the W+1-bit trial value t = {rem_reg, qreg[W-1]} - {0,|y|}.
  - If t >= 0: rem_reg <= t[W-1:0] and shift 1 into qreg.
  - Otherwise: rem_reg <= {rem_reg[W-2:0], qreg[W-1]} and shift 0 into qreg.
- Fixup (combinational from registers; S==W+1 is the cycle that matters):
  - Truncated results: qt = (neg_x^neg_y) ? -qreg : qreg; rt = neg_x ? -rem_reg : rem_reg.
  - If u & (neg_x^neg_y) & (rt!=0): quot = qt-1, rem = rt+y. Otherwise quot=qt, rem=rt.
  - Result satisfies x = quot*y + rem, with rem zero or the same sign as y.
- Divide by zero (div0=1), either mode: quot = all ones, rem = x as sampled. This overrides the fixup.
- Signed overflow (x=-2^(W-1), y=-1): quot wraps to -2^(W-1), rem=0. No trap, no flag.
- run dropped mid-operation: S returns to 0 on the next edge and the partial result is abandoned. The next run starts a fresh full-latency divide.
- rst asserted mid-operation: immediate abort, all state cleared.
- Back-to-back divides: run low for at least one cycle between operations is required. This is the same CPU contract as the multiplier.

Decomposition:
- Shared package holds:
  - W default.
  - S_LOAD = 0 and S_DONE = W+1.
  - Counter width = clog2(W+2).
- One natural sub-module: div_sign_fixup. It is purely combinational and maps (qreg, rem_reg, y, neg_x, neg_y, u, div0, x_saved) to (quot, rem).
  - Its intent is independent unit testing of the sign rules.
  - Because it is combinational, x must also be saved at load to support the div0 result.

Test Plan:
- Unsigned: u=0, x=100, y=7, run held → stall high 33 cycles, then quot=14, rem=2 with stall=0.
- Signed, negative dividend: u=1, x=-7, y=2 → quot=0xFFFFFFFC (-4), rem=1.
- Signed, negative divisor: u=1, x=7, y=-2 → quot=-4, rem=0xFFFFFFFF (-1). Also x=-7, y=-2 → quot=3, rem=-1.
- Divide by zero and overflow:
  - u=1, x=5, y=0 → quot=0xFFFFFFFF, rem=5.
  - u=1, x=0x80000000, y=-1 → quot=0x80000000, rem=0.
- Operand hold: change x and y to random values at S=1..32 during a 100/7 divide → result is still 14/2.
- Aborts:
  - Drop run at S=10 → S=0 next cycle. Re-raise run with x=9, y=3 → 33 stall cycles, then quot=3, rem=0.
  - Pulse rst low at S=20 → stall follows run, quot=rem=0 immediately.
  - Run held after done → S stays at 33, stall stays 0, outputs stable.
